irq_ctrl_mem: RTL and testbench
===============================

IRQ_CTRL_MEM -- requirements
Module: irq_ctrl_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, bus data width.
REQ-003 Parameter NUM_SRC, default 8, interrupt source count, legal range 1..8.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  transaction strobe; must go low between commands.
REQ-007 wr_en  input  1  1=write, 0=read.
REQ-008 addr  input  ADDR_WIDTH  register address, full-width compare.
REQ-009 i_data  input  DATA_WIDTH  write data; only [NUM_SRC-1:0] used.
REQ-010 be  input  DATA_WIDTH/8  byte lanes; lane 0 mandatory, others ignored.
REQ-011 ready  output  1  transaction complete.
REQ-012 o_data  output  DATA_WIDTH  read data, zero-extended.
REQ-013 bus_err  output  1  transaction error, gated by rst_n.
REQ-014 irq_src  input  NUM_SRC  peripheral irq lines (e.g. timer irq), clk domain, active high.
REQ-015 cpu_irq  output  1  registered OR of enabled pending bits.
REQ-016 irq_id  output  3  index of highest-priority enabled pending source.
REQ-017 irq_valid  output  1  irq_id meaningful; equals cpu_irq.

Function
REQ-018 Register map: 0x00 PENDING (R, W1C); 0x01 ENABLE (RW); 0x02 MODE (RW, 1=edge, 0=level); 0x03 CLAIM (R only); 0x04 RAW (R only); any other addr SHALL set error.
REQ-019 Edge mode: pending[i] set on the clock where irq_src[i]=1 and prev[i]=0; prev[i] registers irq_src[i] every cycle.
REQ-020 Edge mode: W1C to PENDING clears bits where i_data=1; set event in the same cycle as clear wins (bit stays 1).
REQ-021 Level mode: pending[i] follows irq_src[i] registered one cycle; W1C and CLAIM have no effect on it.
REQ-022 Changing MODE of a source from level to edge SHALL clear its pending bit; edge to level loads current level next cycle.
REQ-023 Priority: lowest index wins; irq_id/irq_valid/cpu_irq registered from pending & enable, asserting one clock after pending sets (two clocks after irq_src rise in edge mode).
REQ-024 No enabled pending bit: cpu_irq=0, irq_valid=0, irq_id=0.
REQ-025 CLAIM read returns {24'b0, irq_valid, 4'b0, irq_id}; if valid and source is edge mode, that pending bit clears in the same cycle (set event in that cycle still wins).
REQ-026 RAW read returns irq_src registered; PENDING/ENABLE/MODE reads return value zero-extended from NUM_SRC bits.
REQ-027 Writes to CLAIM or RAW SHALL set error; register state unchanged.
REQ-028 Bus FSM states ISSUE, RETIRE: in ISSUE with enable=1, ready=0, error=0: perform access, latch o_data, go RETIRE; in RETIRE: ready<=1.
REQ-029 ready and error hold until enable=0; then ready<=0, error<=0, state<=ISSUE; write/read latency enable-high to ready = 2 clocks.
REQ-030 be[0]=0 with enable=1: ready<=1, error<=1 next clock, no register access.
REQ-031 Interrupt capture continues every cycle regardless of bus state or error.
REQ-032 Bits of ENABLE/MODE/PENDING at index >= NUM_SRC read 0, ignore writes.

Reset
REQ-033 rst_n low asynchronously: PENDING=0, ENABLE=0, MODE=0, prev=0, state=ISSUE, ready=0, error=0, o_data=0, cpu_irq=0, irq_valid=0, irq_id=0.
REQ-034 Reset mid-transaction aborts it; first access after release starts in ISSUE; bus_err=0 while rst_n=0.

Verification
REQ-035 MODE=0xFF, ENABLE=0x04, pulse irq_src[2] one clock -> PENDING=0x04, cpu_irq=1 two clocks after rise, irq_id=2; W1C 0x04 -> cpu_irq=0.
REQ-036 Edge sources 1 and 5 pending, ENABLE=0x22 -> irq_id=1; CLAIM read returns 0x81, next CLAIM returns 0x85, third returns 0x00.
REQ-037 Level source 0 held high, ENABLE=0x01 -> W1C 0x01 leaves PENDING bit0=1; drop irq_src[0] -> cpu_irq=0 two clocks later.
REQ-038 Edge on irq_src[3] same clock as W1C 0x08 -> PENDING bit3=1 afterward.
REQ-039 Write addr 0x03, read addr 0x07, access with be=4'b1110 -> each gives ready=1, bus_err=1 two clocks after enable; both clear one clock after enable drops.
REQ-040 Assert rst_n=0 during RETIRE with pending=0xFF -> all outputs 0 immediately; next read of PENDING after release returns 0x00.

Source files
------------

// File: rtl/irq_ctrl_mem_if.sv
// Bus-side handshake bundle for irq_ctrl_mem: strobe/command from the master,
// completion, read data and error back from the controller.
interface irq_ctrl_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    enable;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   i_data;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   o_data;
  logic                    bus_err;

  modport master (
    output enable, wr_en, addr, i_data, be,
    input  ready, o_data, bus_err
  );

  modport slave (
    input  enable, wr_en, addr, i_data, be,
    output ready, o_data, bus_err
  );
endinterface

// File: rtl/irq_ctrl_mem.sv
// Memory-mapped interrupt controller: per-source edge/level capture, enable mask,
// fixed lowest-index priority, claim register and a two-state bus handshake.
module irq_ctrl_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_ctrl_mem_if.slave      bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq,
  output logic [2:0]         irq_id,
  output logic               irq_valid
);

  localparam logic [ADDR_WIDTH-1:0] A_PENDING = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_ENABLE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_MODE    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_CLAIM   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_RAW     = ADDR_WIDTH'(4);

  typedef enum logic {ISSUE, RETIRE} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
  logic [NUM_SRC-1:0]      pending_q, pending_d;
  logic [NUM_SRC-1:0]      irq_en_q, irq_en_d;
  logic [NUM_SRC-1:0]      mode_q, mode_d;
  logic [NUM_SRC-1:0]      prev_q;
  logic                    cpu_irq_q, cpu_irq_d;
  logic [2:0]              irq_id_q, irq_id_d;
  logic                    do_w1c, do_wr_en, do_wr_mode, do_claim;
  logic [NUM_SRC-1:0]      wdata, clr, set_ev, active;
  logic                    unused_bus;

  assign wdata      = bus.i_data[NUM_SRC-1:0];
  assign unused_bus = ^{bus.i_data, bus.be};

  // Bus handshake: access happens on the ISSUE edge, completion is shown in RETIRE
  // so ready and bus_err rise together two clocks after the strobe.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    error_d    = error_q;
    err_d      = err_q;
    o_data_d   = o_data_q;
    do_w1c     = 1'b0;
    do_wr_en   = 1'b0;
    do_wr_mode = 1'b0;
    do_claim   = 1'b0;
    case (state_q)
      ISSUE: begin
        if (bus.enable && !ready_q && !error_q) begin
          state_d  = RETIRE;
          err_d    = 1'b0;
          o_data_d = '0;
          if (!bus.be[0]) begin
            err_d = 1'b1;
          end else if (bus.wr_en) begin
            case (bus.addr)
              A_PENDING: do_w1c     = 1'b1;
              A_ENABLE:  do_wr_en   = 1'b1;
              A_MODE:    do_wr_mode = 1'b1;
              default:   err_d      = 1'b1;
            endcase
          end else begin
            case (bus.addr)
              A_PENDING: o_data_d = DATA_WIDTH'(pending_q);
              A_ENABLE:  o_data_d = DATA_WIDTH'(irq_en_q);
              A_MODE:    o_data_d = DATA_WIDTH'(mode_q);
              A_CLAIM: begin
                o_data_d = DATA_WIDTH'({cpu_irq_q, 4'b0000, irq_id_q});
                do_claim = 1'b1;
              end
              A_RAW:     o_data_d = DATA_WIDTH'(prev_q);
              default:   err_d    = 1'b1;
            endcase
          end
        end
      end
      RETIRE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
          error_d = err_q;
        end else if (!bus.enable) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // Pending update uses the mode taking effect at this edge: a source switched to
  // level samples its line at once, a source switched to edge starts cleared.
  always_comb begin
    irq_en_d = do_wr_en   ? wdata : irq_en_q;
    mode_d   = do_wr_mode ? wdata : mode_q;
    set_ev   = irq_src & ~prev_q;
    clr      = do_w1c ? wdata : '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (do_claim && cpu_irq_q && (irq_id_q == 3'(i)) && mode_q[i])
        clr[i] = 1'b1;
    end
    pending_d = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!mode_d[i])
        pending_d[i] = irq_src[i];
      else if (!mode_q[i])
        pending_d[i] = 1'b0;
      else
        pending_d[i] = (pending_q[i] & ~clr[i]) | set_ev[i];
    end
    active    = pending_q & irq_en_q;
    cpu_irq_d = |active;
    irq_id_d  = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (active[i-1])
        irq_id_d = 3'(i-1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ISSUE;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      err_q     <= 1'b0;
      o_data_q  <= '0;
      pending_q <= '0;
      irq_en_q  <= '0;
      mode_q    <= '0;
      prev_q    <= '0;
      cpu_irq_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      err_q     <= err_d;
      o_data_q  <= o_data_d;
      pending_q <= pending_d;
      irq_en_q  <= irq_en_d;
      mode_q    <= mode_d;
      prev_q    <= irq_src;
      cpu_irq_q <= cpu_irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.o_data  = o_data_q;
  assign bus.bus_err = error_q & rst_n;
  assign cpu_irq     = cpu_irq_q;
  assign irq_valid   = cpu_irq_q;
  assign irq_id      = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl_mem.sv
// Randomized self-checking bench for irq_ctrl_mem against a cycle-level
// behavioural model of the register map and priority rules.
module tb_irq_ctrl_mem;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_src;
  logic       cpu_irq;
  logic [2:0] irq_id;
  logic       irq_valid;

  int checks   = 0;
  int failures = 0;

  irq_ctrl_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  irq_ctrl_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SRC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif),
    .irq_src   (irq_src),
    .cpu_irq   (cpu_irq),
    .irq_id    (irq_id),
    .irq_valid (irq_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_pend, m_en, m_mode, m_prev;
  logic        m_valid;
  logic [2:0]  m_id;
  logic [31:0] exp_rd;
  logic        exp_err;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0; m_valid = 1'b0; m_id = '0;
  endtask

  // Advance one clock; when acc is set, the bus command currently driven is
  // applied to the model at this edge.
  task automatic model_step(input bit acc);
    logic [7:0] src, clr, n_en, n_mode, n_pend, act;
    src = irq_src; clr = '0; n_en = m_en; n_mode = m_mode;
    if (acc) begin
      exp_rd = '0; exp_err = 1'b0;
      if (!bif.be[0]) exp_err = 1'b1;
      else if (bif.wr_en) begin
        if (bif.addr == 32'd0)      clr    = bif.i_data[7:0];
        else if (bif.addr == 32'd1) n_en   = bif.i_data[7:0];
        else if (bif.addr == 32'd2) n_mode = bif.i_data[7:0];
        else exp_err = 1'b1;
      end else begin
        if (bif.addr == 32'd0)      exp_rd = {24'b0, m_pend};
        else if (bif.addr == 32'd1) exp_rd = {24'b0, m_en};
        else if (bif.addr == 32'd2) exp_rd = {24'b0, m_mode};
        else if (bif.addr == 32'd3) begin
          exp_rd = {24'b0, m_valid, 4'b0, m_id};
          if (m_valid && m_mode[m_id]) clr[m_id] = 1'b1;
        end
        else if (bif.addr == 32'd4) exp_rd = {24'b0, m_prev};
        else exp_err = 1'b1;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (!n_mode[i])     n_pend[i] = src[i];
      else if (!m_mode[i]) n_pend[i] = 1'b0;
      else n_pend[i] = (m_pend[i] & ~clr[i]) | (src[i] & ~m_prev[i]);
    end
    act = m_pend & m_en;
    @(posedge clk);
    m_valid = (act != 8'h00);
    m_id    = lowest(act);
    m_pend  = n_pend; m_en = n_en; m_mode = n_mode; m_prev = src;
    #1;
  endtask

  task automatic bus_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [7:0] s,
                        output logic [31:0] rdata, output logic err);
    irq_src = s;
    bif.enable = 1'b1; bif.wr_en = wr; bif.addr = a; bif.i_data = d; bif.be = b;
    model_step(1'b1);
    checks++;
    if (bif.ready !== 1'b0 || bif.bus_err !== 1'b0) begin
      failures++;
      $display("FAIL early_ready addr=%h: ready=%b bus_err=%b want 0 0", a, bif.ready, bif.bus_err);
    end
    model_step(1'b0);
    checks++;
    if (bif.ready !== 1'b1 || bif.bus_err !== exp_err) begin
      failures++;
      $display("FAIL complete addr=%h: ready=%b bus_err=%b want 1 %b", a, bif.ready, bif.bus_err, exp_err);
    end
    if (!wr && !exp_err) begin
      checks++;
      if (bif.o_data !== exp_rd) begin
        failures++;
        $display("FAIL read_data addr=%h: got %h want %h", a, bif.o_data, exp_rd);
      end
    end
    rdata = bif.o_data; err = bif.bus_err;
    model_step(1'b0);
    checks++;
    if (bif.ready !== 1'b1 || bif.bus_err !== exp_err) begin
      failures++;
      $display("FAIL hold addr=%h: ready=%b bus_err=%b want 1 %b", a, bif.ready, bif.bus_err, exp_err);
    end
    bif.enable = 1'b0;
    model_step(1'b0);
    checks++;
    if (bif.ready !== 1'b0 || bif.bus_err !== 1'b0) begin
      failures++;
      $display("FAIL release addr=%h: ready=%b bus_err=%b want 0 0", a, bif.ready, bif.bus_err);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e;
    rst_n = 1'b0; irq_src = '0;
    bif.enable = 1'b0; bif.wr_en = 1'b0; bif.addr = '0; bif.i_data = '0; bif.be = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bif.ready, bif.bus_err, cpu_irq, irq_valid, irq_id} !== 7'b0 || bif.o_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b err=%b cpu=%b valid=%b id=%0d o_data=%h want all 0",
               bif.ready, bif.bus_err, cpu_irq, irq_valid, irq_id, bif.o_data);
    end
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bus_op(1'b0, 32'(r), 32'h0, 4'hF, 8'h00, rd, e);
      checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h want 0", r, rd);
      end
    end
  endtask

  task automatic test_edge_pulse();
    logic [31:0] rd; logic e;
    bus_op(1'b1, 32'd2, 32'hFF, 4'hF, 8'h00, rd, e);
    bus_op(1'b1, 32'd1, 32'h04, 4'hF, 8'h00, rd, e);
    irq_src = 8'h04;
    model_step(1'b0);
    checks++;
    if (cpu_irq !== 1'b0) begin
      failures++;
      $display("FAIL edge_early: cpu_irq=%b want 0", cpu_irq);
    end
    irq_src = 8'h00;
    model_step(1'b0);
    checks++;
    if (cpu_irq !== 1'b1 || irq_valid !== 1'b1 || irq_id !== 3'd2) begin
      failures++;
      $display("FAIL edge_irq: cpu=%b valid=%b id=%0d want 1 1 2", cpu_irq, irq_valid, irq_id);
    end
    bus_op(1'b0, 32'd0, 32'h0, 4'hF, 8'h00, rd, e);
    checks++;
    if (rd !== 32'h04) begin
      failures++;
      $display("FAIL edge_pending: got %h want 00000004", rd);
    end
    bus_op(1'b1, 32'd0, 32'h04, 4'hF, 8'h00, rd, e);
    checks++;
    if (cpu_irq !== 1'b0 || irq_valid !== 1'b0 || irq_id !== 3'd0) begin
      failures++;
      $display("FAIL edge_w1c: cpu=%b valid=%b id=%0d want 0 0 0", cpu_irq, irq_valid, irq_id);
    end
  endtask

  task automatic test_claim();
    logic [31:0] rd; logic e;
    logic [31:0] want [3];
    want[0] = 32'h81; want[1] = 32'h85; want[2] = 32'h00;
    bus_op(1'b1, 32'd1, 32'h22, 4'hF, 8'h00, rd, e);
    irq_src = 8'h22;
    model_step(1'b0);
    irq_src = 8'h00;
    model_step(1'b0);
    model_step(1'b0);
    checks++;
    if (irq_id !== 3'd1 || cpu_irq !== 1'b1) begin
      failures++;
      $display("FAIL claim_prio: id=%0d cpu=%b want 1 1", irq_id, cpu_irq);
    end
    for (int k = 0; k < 3; k++) begin
      bus_op(1'b0, 32'd3, 32'h0, 4'hF, 8'h00, rd, e);
      checks++;
      if (rd !== want[k]) begin
        failures++;
        $display("FAIL claim_%0d: got %h want %h", k, rd, want[k]);
      end
    end
  endtask

  task automatic test_level();
    logic [31:0] rd; logic e;
    bus_op(1'b1, 32'd2, 32'hFE, 4'hF, 8'h00, rd, e);
    bus_op(1'b1, 32'd1, 32'h01, 4'hF, 8'h01, rd, e);
    bus_op(1'b1, 32'd0, 32'h01, 4'hF, 8'h01, rd, e);
    bus_op(1'b0, 32'd0, 32'h0, 4'hF, 8'h01, rd, e);
    checks++;
    if (rd[0] !== 1'b1 || cpu_irq !== 1'b1) begin
      failures++;
      $display("FAIL level_w1c: pending=%h cpu=%b want bit0=1 cpu=1", rd, cpu_irq);
    end
    irq_src = 8'h00;
    model_step(1'b0);
    checks++;
    if (cpu_irq !== 1'b1) begin
      failures++;
      $display("FAIL level_drop1: cpu_irq=%b want 1", cpu_irq);
    end
    model_step(1'b0);
    checks++;
    if (cpu_irq !== 1'b0) begin
      failures++;
      $display("FAIL level_drop2: cpu_irq=%b want 0", cpu_irq);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd; logic e;
    bus_op(1'b1, 32'd2, 32'hFF, 4'hF, 8'h00, rd, e);
    bus_op(1'b1, 32'd0, 32'h08, 4'hF, 8'h08, rd, e);
    bus_op(1'b0, 32'd0, 32'h0, 4'hF, 8'h00, rd, e);
    checks++;
    if (rd[3] !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: pending=%h want bit3=1", rd);
    end
    bus_op(1'b1, 32'd0, 32'hFF, 4'hF, 8'h00, rd, e);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e;
    logic [31:0] a  [5];
    bit          w  [5];
    logic [3:0]  bb [5];
    a[0] = 32'd3;     w[0] = 1'b1; bb[0] = 4'hF;
    a[1] = 32'd7;     w[1] = 1'b0; bb[1] = 4'hF;
    a[2] = 32'd1;     w[2] = 1'b1; bb[2] = 4'b1110;
    a[3] = 32'h100;   w[3] = 1'b0; bb[3] = 4'hF;
    a[4] = 32'd4;     w[4] = 1'b1; bb[4] = 4'hF;
    for (int k = 0; k < 5; k++) begin
      bus_op(w[k], a[k], 32'hFF, bb[k], 8'h00, rd, e);
      checks++;
      if (e !== 1'b1) begin
        failures++;
        $display("FAIL err_%0d addr=%h be=%b: bus_err=%b want 1", k, a[k], bb[k], e);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic e;
    int unsigned op;
    bus_op(1'b1, 32'd2, 32'($urandom_range(0, 255)), 4'hF, 8'h00, rd, e);
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 5);
      if (op < 3) begin
        irq_src = 8'($urandom);
        model_step(1'b0);
      end else if (op == 3) begin
        bus_op(1'b0, 32'($urandom_range(0, 4)), 32'h0, 4'hF, 8'($urandom), rd, e);
      end else begin
        bus_op(1'b1, 32'($urandom_range(0, 1)), 32'($urandom), 4'hF, 8'($urandom), rd, e);
      end
      checks++;
      if (cpu_irq !== m_valid || irq_valid !== m_valid || irq_id !== (m_valid ? m_id : 3'd0)) begin
        failures++;
        $display("FAIL rand_irq n=%0d: cpu=%b valid=%b id=%0d want %b %b %0d",
                 n, cpu_irq, irq_valid, irq_id, m_valid, m_valid, m_id);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e;
    bus_op(1'b1, 32'd2, 32'h00, 4'hF, 8'hFF, rd, e);
    bus_op(1'b1, 32'd1, 32'hFF, 4'hF, 8'hFF, rd, e);
    bif.enable = 1'b1; bif.wr_en = 1'b0; bif.addr = 32'd0; bif.be = 4'hF;
    model_step(1'b1);
    model_step(1'b0);
    checks++;
    if (bif.ready !== 1'b1 || cpu_irq !== 1'b1 || bif.o_data !== 32'hFF) begin
      failures++;
      $display("FAIL pre_reset: ready=%b cpu=%b o_data=%h want 1 1 000000ff", bif.ready, cpu_irq, bif.o_data);
    end
    #2 rst_n = 1'b0;
    irq_src = 8'h00;
    #1;
    checks++;
    if ({bif.ready, bif.bus_err, cpu_irq, irq_valid, irq_id} !== 7'b0 || bif.o_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: ready=%b err=%b cpu=%b valid=%b id=%0d o_data=%h want all 0",
               bif.ready, bif.bus_err, cpu_irq, irq_valid, irq_id, bif.o_data);
    end
    bif.enable = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_op(1'b0, 32'd0, 32'h0, 4'hF, 8'h00, rd, e);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_pending: got %h want 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_edge_pulse();
    test_claim();
    test_level();
    test_set_wins();
    test_errors();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
